// File: rtl/c2c_mem_slave.sv
// c2c_mem_slave: word-organised memory acting as the responder on one c2c
// read channel and one c2c write channel. The two channels run
// independently, each with an IDLE/WAIT/ACK handshake and a fixed access
// latency.
//
// Parameters:
//   XLEN    - address/data width in bits (multiple of 8)
//   DEPTH   - memory size in XLEN-bit words (power of two, >= 2)
//   LATENCY - cycles from request sampled to acknowledge (>= 1)
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   reset  in   asynchronous active-high reset
//   r_req  in   read request, held with r_addr until r_ack
//   r_addr in   read byte address
//   r_ack  out  one-cycle pulse, r_data valid in this cycle
//   r_data out  registered read data
//   w_req  in   write request, held with w_addr/w_data/w_strb until w_ack
//   w_addr in   write byte address
//   w_data in   write data
//   w_strb in   byte enables, bit i enables w_data[8i+7:8i]
//   w_ack  out  one-cycle pulse, write commits at the end of this cycle
module c2c_mem_slave #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r_req,
  input  logic [XLEN-1:0]   r_addr,
  output logic              r_ack,
  output logic [XLEN-1:0]   r_data,
  input  logic              w_req,
  input  logic [XLEN-1:0]   w_addr,
  input  logic [XLEN-1:0]   w_data,
  input  logic [XLEN/8-1:0] w_strb,
  output logic              w_ack
);

  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  // Channel 0 is the read channel, channel 1 the write channel.
  logic [1:0] w_req_vec;
  logic [1:0] w_ack_vec;
  logic [1:0] w_enter_ack_vec;

  assign w_req_vec = {w_req, r_req};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_ack_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_ack_q <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
        // Ack is registered from the next state so it leaves a flop.
        r_ack_q <= (w_state_next == ST_ACK);
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
        ST_IDLE: begin
          if (w_req_vec[gi]) begin
            w_cnt_next   = CNT_LOAD;
            w_state_next = (LATENCY == 1) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!w_req_vec[gi]) begin
            // Requester withdrew: abort without ack or memory effect.
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              w_state_next = ST_ACK;
            end
          end
        end
        default: begin
          // ACK lasts one cycle; a request seen here is ignored.
          w_state_next = ST_IDLE;
        end
      endcase
    end

    assign w_ack_vec[gi]       = r_ack_q;
    assign w_enter_ack_vec[gi] = (w_state_next == ST_ACK);
  end

  // Memory array and address decode.
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_data_q;
  logic [AW-1:0]   w_rd_idx;
  logic [AW-1:0]   w_wr_idx;
  logic            w_rd_in_range;
  logic            w_wr_in_range;
  logic            w_commit;
  logic            w_same_word;
  logic [XLEN-1:0] w_rd_word;
  logic [XLEN-1:0] w_rd_fwd;
  logic            w_unused_lsbs;

  assign w_rd_idx      = r_addr[OFF +: AW];
  assign w_wr_idx      = w_addr[OFF +: AW];
  assign w_rd_in_range = (r_addr[XLEN-1:OFF+AW] == '0);
  assign w_wr_in_range = (w_addr[XLEN-1:OFF+AW] == '0);
  // Byte-offset bits never select anything.
  assign w_unused_lsbs = ^{r_addr[OFF-1:0], w_addr[OFF-1:0]};

  // The write lands on the edge that leaves ACK; out-of-range writes drop.
  assign w_commit    = w_ack_vec[1] && w_wr_in_range;
  assign w_same_word = w_commit && w_rd_in_range && (w_rd_idx == w_wr_idx);
  assign w_rd_word   = w_rd_in_range ? r_mem[w_rd_idx] : '0;

  // A read capturing on the commit edge of the same word sees the new bytes.
  for (genvar gi = 0; gi < NB; gi++) begin : g_fwd
    assign w_rd_fwd[8*gi +: 8] = (w_same_word && w_strb[gi]) ? w_data[8*gi +: 8]
                                                             : w_rd_word[8*gi +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_q <= '0;
    end else if (w_enter_ack_vec[0]) begin
      r_data_q <= w_rd_fwd;
    end
  end

  // Array contents are deliberately outside the reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (w_strb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  assign r_ack  = w_ack_vec[0];
  assign w_ack  = w_ack_vec[1];
  assign r_data = r_data_q;

endmodule
